// File: rtl/rvk_tag_ctrl_if.sv
// Revocation tag controller bus bundle: load-completion input, bitmap read
// port, register-file kill snoop and trvk clear command.
interface rvk_tag_ctrl_if;
    logic        ld_cap_valid_i;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_base_i;
    logic        ld_ready_o;

    logic        rf_we0_i;
    logic        rf_we1_i;
    logic        rf_we2_i;
    logic [4:0]  rf_waddr0_i;
    logic [4:0]  rf_waddr1_i;
    logic [4:0]  rf_waddr2_i;

    logic        rvk_req_o;
    logic [31:0] rvk_addr_o;
    logic        rvk_gnt_i;
    logic        rvk_rvalid_i;
    logic [31:0] rvk_rdata_i;

    logic        trvk_en_o;
    logic        trvk_clrtag_o;
    logic [4:0]  trvk_addr_o;
    logic        busy_o;

    // Controller side.
    modport master (
        input  ld_cap_valid_i, ld_rd_i, ld_base_i,
        input  rf_we0_i, rf_we1_i, rf_we2_i, rf_waddr0_i, rf_waddr1_i, rf_waddr2_i,
        input  rvk_gnt_i, rvk_rvalid_i, rvk_rdata_i,
        output ld_ready_o, rvk_req_o, rvk_addr_o,
        output trvk_en_o, trvk_clrtag_o, trvk_addr_o, busy_o
    );

    // Writeback / memory / register-file side.
    modport slave (
        output ld_cap_valid_i, ld_rd_i, ld_base_i,
        output rf_we0_i, rf_we1_i, rf_we2_i, rf_waddr0_i, rf_waddr1_i, rf_waddr2_i,
        output rvk_gnt_i, rvk_rvalid_i, rvk_rdata_i,
        input  ld_ready_o, rvk_req_o, rvk_addr_o,
        input  trvk_en_o, trvk_clrtag_o, trvk_addr_o, busy_o
    );
endinterface

// File: rtl/rvk_tag_ctrl.sv
// Revocation tag controller: queues capability loads, reads the revocation
// bitmap per load and issues trvk tag clears. Optional heap range check: KUDU_RVK_RANGE_CHK_EN.
module rvk_tag_ctrl #(
    parameter int unsigned QDepth    = 4,
    parameter logic [31:0] HeapBase  = 32'h8000_0000,
    parameter logic [31:0] HeapSize  = 32'h0004_0000,
    parameter logic [31:0] RvkBase   = 32'h8300_0000,
    parameter bit          CHERIoTEn = 1'b1
) (
    input logic           clk_i,
    input logic           rst_ni,
    rvk_tag_ctrl_if.master bus
);

    localparam int unsigned PtrW = $clog2(QDepth);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    state_e state_q, state_d;

    // FIFO storage; entries hold the granule index (offs[31:3]) only.
    logic [4:0]        q_rd   [QDepth];
    logic [28:0]       q_gran [QDepth];
    logic [QDepth-1:0] q_killed;
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [PtrW:0]     count_q;

    logic [4:0]  cur_rd_q;
    logic [4:0]  cur_bit_q;
    logic        cur_killed_q;
    logic [31:0] rvk_addr_q;

    logic        trvk_en_q;
    logic        trvk_clr_q;
    logic [4:0]  trvk_addr_q;

    logic        full, empty, push, pop;
    logic        head_killed, head_oor, rsp_fire, req;
    logic [4:0]  head_rd;
    logic [28:0] head_gran;
    logic [31:0] push_offs;
    logic        unused_offs_lsb;

    logic [2:0]  rf_we;
    logic [4:0]  rf_waddr [3];

    assign rf_we       = {bus.rf_we2_i, bus.rf_we1_i, bus.rf_we0_i};
    assign rf_waddr[0] = bus.rf_waddr0_i;
    assign rf_waddr[1] = bus.rf_waddr1_i;
    assign rf_waddr[2] = bus.rf_waddr2_i;

    function automatic logic kill_hit(input logic [4:0] rd);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (rf_we[i] && (rf_waddr[i] == rd)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign full        = (count_q == (PtrW+1)'(QDepth));
    assign empty       = (count_q == '0);
    assign push        = CHERIoTEn && bus.ld_cap_valid_i && !full && (bus.ld_rd_i != '0);
    assign pop         = (state_q == IDLE) && !empty;
    assign push_offs   = bus.ld_base_i - HeapBase;
    assign unused_offs_lsb = ^push_offs[2:0];

    assign head_rd     = q_rd[rptr_q];
    assign head_gran   = q_gran[rptr_q];
    assign head_killed = q_killed[rptr_q];

`ifdef KUDU_RVK_RANGE_CHK_EN
    // HeapSize is a multiple of 256, so comparing granule indices is exact.
    assign head_oor = (head_gran >= HeapSize[31:3]);
`else
    assign head_oor = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop && !head_killed && !head_oor) state_d = REQ;
            REQ:     if (bus.rvk_gnt_i) state_d = WAIT;
            WAIT:    if (bus.rvk_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req      = 1'b0;
        rsp_fire = 1'b0;
        unique case (state_q)
            REQ:     req = 1'b1;
            WAIT:    rsp_fire = bus.rvk_rvalid_i;
            default: ;
        endcase
    end

    // Pending-entry FIFO; a write in the push cycle is the load itself, so
    // the freshly written slot overrides the kill sweep.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            q_killed <= '0;
        end else begin
            for (int unsigned i = 0; i < QDepth; i++) begin
                if (kill_hit(q_rd[i])) q_killed[i] <= 1'b1;
            end
            if (push) begin
                q_rd[wptr_q]     <= bus.ld_rd_i;
                q_gran[wptr_q]   <= push_offs[31:3];
                q_killed[wptr_q] <= 1'b0;
                wptr_q           <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // In-flight entry and registered trvk command.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cur_rd_q     <= '0;
            cur_bit_q    <= '0;
            cur_killed_q <= 1'b0;
            rvk_addr_q   <= '0;
            trvk_en_q    <= 1'b0;
            trvk_clr_q   <= 1'b0;
            trvk_addr_q  <= '0;
        end else begin
            trvk_en_q  <= rsp_fire;
            trvk_clr_q <= rsp_fire && bus.rvk_rdata_i[cur_bit_q]
                          && !cur_killed_q && !kill_hit(cur_rd_q);
            if (rsp_fire) trvk_addr_q <= cur_rd_q;

            if (pop) begin
                cur_rd_q     <= head_rd;
                cur_bit_q    <= head_gran[4:0];
                cur_killed_q <= head_killed | kill_hit(head_rd);
                rvk_addr_q   <= RvkBase + {6'b0, head_gran[28:5], 2'b00};
            end else if (kill_hit(cur_rd_q)) begin
                cur_killed_q <= 1'b1;
            end
        end
    end

    assign bus.ld_ready_o    = CHERIoTEn ? !full : 1'b1;
    assign bus.rvk_req_o     = CHERIoTEn && req;
    assign bus.rvk_addr_o    = rvk_addr_q;
    assign bus.trvk_en_o     = CHERIoTEn && trvk_en_q;
    assign bus.trvk_clrtag_o = CHERIoTEn && trvk_clr_q;
    assign bus.trvk_addr_o   = trvk_addr_q;
    assign bus.busy_o        = !empty || (state_q != IDLE);

    // Pushing into a full queue drops the entry.
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.ld_cap_valid_i |-> bus.ld_ready_o);

endmodule
